// File: rtl/onehot_pulse_decoder.sv
// onehot_pulse_decoder
// Accepts 3-bit code words from an upstream priority encoder over a
// valid/ready handshake. Each accepted code drives the matching line of a
// one-hot output for HOLD cycles. A word whose code-valid flag is low is
// consumed and reported on null_seen, and it produces no output pulse.
//
// Optional build macro: DEC_GAP_EN
//   When it is defined, the block inserts GAP idle cycles after each pulse.
//   During those cycles the output is zero and in_ready is low.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   in_valid       code word present
//   in_ready       block can accept a word (decoded from state only)
//   in_code        encoded index
//   in_code_valid  0 = "no request" word
//   out_onehot     registered one-hot line, zero when idle
//   out_active     high while out_onehot is non-zero
//   done           high on the last cycle of a pulse
//   null_seen      one-cycle pulse after a null word is accepted
//
// state | meaning
// IDLE  | ready for a code word, output zero
// DRIVE | one-hot line driven, hold counter running down to 0
// GAP   | post-pulse idle, gap counter running (DEC_GAP_EN only)
module onehot_pulse_decoder #(
  parameter int CODE_W = 3,
  parameter int HOLD   = 4,
  parameter int GAP    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CODE_W-1:0]      in_code,
  input  logic                   in_code_valid,
  output logic [2**CODE_W-1:0]   out_onehot,
  output logic                   out_active,
  output logic                   done,
  output logic                   null_seen
);

  localparam int OUT_W = 2**CODE_W;

  if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
    $error("onehot_pulse_decoder: HOLD must be 1..255");
  end
  if (GAP < 1 || GAP > 255) begin : g_bad_gap
    $error("onehot_pulse_decoder: GAP must be 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1
`ifdef DEC_GAP_EN
    ,
    ST_GAP   = 2'd2
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   onehot_q, onehot_d;
  logic [7:0]         hold_cnt_q, hold_cnt_d;
  logic               null_q, null_d;
`ifdef DEC_GAP_EN
  logic [7:0]         gap_cnt_q, gap_cnt_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      onehot_q   <= '0;
      hold_cnt_q <= '0;
      null_q     <= 1'b0;
`ifdef DEC_GAP_EN
      gap_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      onehot_q   <= onehot_d;
      hold_cnt_q <= hold_cnt_d;
      null_q     <= null_d;
`ifdef DEC_GAP_EN
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    onehot_d   = onehot_q;
    hold_cnt_d = hold_cnt_q;
    null_d     = 1'b0;
`ifdef DEC_GAP_EN
    gap_cnt_d  = gap_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // in_ready is 1 only in IDLE, so in_valid alone marks a handshake here.
        if (in_valid) begin
          if (in_code_valid) begin
            state_d    = ST_DRIVE;
            onehot_d   = OUT_W'(1) << in_code;
            hold_cnt_d = 8'(HOLD - 1);
          end else begin
            null_d = 1'b1;
          end
        end
      end
      ST_DRIVE: begin
        if (hold_cnt_q == 8'd0) begin
          onehot_d = '0;
`ifdef DEC_GAP_EN
          state_d   = ST_GAP;
          gap_cnt_d = 8'(GAP - 1);
`else
          state_d   = ST_IDLE;
`endif
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
`ifdef DEC_GAP_EN
      ST_GAP: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
`endif
      default: begin
        state_d  = ST_IDLE;
        onehot_d = '0;
      end
    endcase
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_active = (state_q == ST_DRIVE);
  assign out_onehot = onehot_q;
  // The counter reaches 0 on the final DRIVE cycle, so done lines up with it.
  assign done       = out_active && (hold_cnt_q == 8'd0);
  assign null_seen  = null_q;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
module tb_onehot_pulse_decoder;

  localparam int TB_HOLD = 4;
  localparam int TB_GAP  = 3;
`ifdef DEC_GAP_EN
  localparam int GAPC = TB_GAP;
`else
  localparam int GAPC = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_code = 3'd0;
  logic       in_code_valid = 1'b0;
  logic [7:0] out_onehot;
  logic       out_active;
  logic       done;
  logic       null_seen;

  onehot_pulse_decoder #(.CODE_W(3), .HOLD(TB_HOLD), .GAP(TB_GAP)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_code       (in_code),
    .in_code_valid (in_code_valid),
    .out_onehot    (out_onehot),
    .out_active    (out_active),
    .done          (done),
    .null_seen     (null_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cv;
    logic [2:0] code;
    int         acc;
  } word_t;

  word_t sb_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc;
  int    ready_at = 0;
  bit    sb_en = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Reference model: a word handed over in cycle e is accepted at the next
  // edge; a valid code occupies cycles e+1..e+HOLD, then GAPC gap cycles,
  // and the block is ready again afterwards. A null word leaves ready alone.
  task automatic send(input logic cv, input logic [2:0] code);
    int    w;
    word_t wd;
    w = 0;
    in_valid      = 1'b1;
    in_code_valid = cv;
    in_code       = code;
    while (cyc < ready_at) begin
      @(negedge clk);
      w++;
      if (w > 100) begin
        errors++;
        $display("FAIL send_timeout: model never ready, cycle %0d", cyc);
        break;
      end
    end
    wd.cv   = cv;
    wd.code = code;
    wd.acc  = cyc;
    sb_q.push_back(wd);
    if (cv) ready_at = cyc + TB_HOLD + GAPC + 1;
    @(negedge clk);
    in_valid = 1'b0;
    in_code  = 3'($urandom);
  endtask

  // Monitor: compares what the DUT presents against the scoreboard queue.
  bit       in_pulse = 1'b0;
  int       pcnt = 0;
  int       cur_val = 0;
  always begin
    word_t wd;
    @(posedge clk);
    #2;
    if (sb_en && !rst) begin
      chk("in_ready", int'(in_ready), int'(cyc >= ready_at));
      chk("active_vs_onehot", int'(out_active), int'(out_onehot != 8'd0));
      if (sb_q.size() > 0 && sb_q[0].acc + 1 < cyc) begin
        wd = sb_q.pop_front();
        errors++;
        $display("FAIL missing_output: word cv=%0d code=%0d accepted cycle %0d never presented, now %0d",
                 wd.cv, wd.code, wd.acc, cyc);
      end
      if (null_seen) begin
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_null: null_seen=1 with empty scoreboard at cycle %0d", cyc);
        end else begin
          wd = sb_q.pop_front();
          chk("null_kind", 0, int'(wd.cv));
          chk("null_latency", cyc, wd.acc + 1);
        end
      end
      if (out_onehot != 8'd0 && !in_pulse) begin
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: out_onehot=0x%0h with empty scoreboard at cycle %0d",
                   out_onehot, cyc);
        end else begin
          wd = sb_q.pop_front();
          chk("pulse_kind", 1, int'(wd.cv));
          chk("pulse_onehot", int'(out_onehot), 1 << wd.code);
          chk("pulse_latency", cyc, wd.acc + 1);
        end
        in_pulse = 1'b1;
        cur_val  = int'(out_onehot);
        pcnt     = 1;
      end else if (in_pulse) begin
        if (out_onehot != 8'd0) begin
          chk("pulse_steady", int'(out_onehot), cur_val);
          pcnt++;
        end else begin
          chk("pulse_length", pcnt, TB_HOLD);
          in_pulse = 1'b0;
        end
      end
      chk("done", int'(done), int'(in_pulse && pcnt == TB_HOLD));
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_onehot", int'(out_onehot), 0);
    chk("rst_active", int'(out_active), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_null", int'(null_seen), 0);

    // Reset mid-pulse on code 3
    rst = 1'b0;
    in_valid = 1'b1; in_code_valid = 1'b1; in_code = 3'd3;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_onehot", int'(out_onehot), 8'h08);
    chk("pre_rst_ready", int'(in_ready), 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_onehot", int'(out_onehot), 0);
    chk("midrst_active", int'(out_active), 0);
    chk("midrst_done", int'(done), 0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_done_hold", int'(done), 0);
    end
    rst = 1'b0;
    #1;
    chk("post_rst_ready", int'(in_ready), 1);
    sb_en = 1'b1;

    // Single code 5
    send(1'b1, 3'd5);
    repeat (TB_HOLD + GAPC + 2) @(negedge clk);
    // Back-to-back 0 then 7 with in_valid held
    send(1'b1, 3'd0);
    send(1'b1, 3'd7);
    // Null word with code 6, then a valid word on the very next cycle
    repeat (TB_HOLD + GAPC + 2) @(negedge clk);
    send(1'b0, 3'd6);
    send(1'b1, 3'd2);
    // Sweep every one-hot bit
    for (int c = 0; c < 8; c++) send(1'b1, 3'(c));

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0, 3'($urandom));
    end

    repeat (TB_HOLD + GAPC + 6) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    chk("end_idle", int'(in_pulse), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
